// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU command issuer: widths, FSM encoding and
// the queued command word layout {load, cin, mode, b}.
package alu_seq_pkg;

    localparam int unsigned WIDTH          = 4;
    localparam int unsigned MODE_W         = 4;
    localparam int unsigned DEPTH          = 4;
    localparam int unsigned CMD_W          = 2 + MODE_W + WIDTH;
    localparam int unsigned MODE_SHIFT_BIT = 3;
    localparam int unsigned PTR_W          = $clog2(DEPTH);
    localparam int unsigned CNT_W          = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } state_t;

    typedef struct packed {
        logic              load;
        logic              cin;
        logic [MODE_W-1:0] mode;
        logic [WIDTH-1:0]  b;
    } cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// DEPTH-entry synchronous command FIFO; push is ignored when full and pop
// when empty, so callers may present requests unconditionally.
module alu_cmd_fifo
    import alu_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [CMD_W-1:0] din,
    input  logic             pop,
    output logic [CMD_W-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [CMD_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Sequences queued commands through an external combinational alushifter,
// keeping a 4-bit accumulator and returning each result over valid/ready.
module alu_cmd_issuer
    import alu_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_load,
    input  logic [MODE_W-1:0] cmd_mode,
    input  logic [WIDTH-1:0]  cmd_b,
    input  logic              cmd_cin,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic              alu_cin,
    output logic [MODE_W-1:0] alu_mode,
    input  logic [WIDTH-1:0]  alu_r,
    input  logic              alu_ovf,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [WIDTH-1:0]  res_data,
    output logic              res_ovf,
    output logic              ovf_sticky,
    output logic              busy
);

    state_t           state;
    state_t           state_d;
    cmd_t             cmd_in;
    cmd_t             head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic             pop;
    logic             capture;
    logic             res_valid_d;
    logic             op_load;
    logic [WIDTH-1:0] acc;
    logic             ovf_now;

    assign cmd_in = {cmd_load, cmd_cin, cmd_mode, cmd_b};

    alu_cmd_fifo u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cmd_valid),
        .din   (cmd_in),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign cmd_ready = !fifo_full;
    assign busy      = (state != IDLE) || (fifo_count != '0);
    assign alu_a     = acc;
    assign res_data  = acc;

    // Only a definite 1 counts as overflow; x/z from an idle or shifting
    // alushifter must never leak into the result flags.
    assign ovf_now = !alu_mode[MODE_SHIFT_BIT] && (alu_ovf === 1'b1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d     = state;
        pop         = 1'b0;
        capture     = 1'b0;
        res_valid_d = res_valid;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = CAPTURE;
            CAPTURE: begin
                capture     = 1'b1;
                res_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand registers stay stable from pop through capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_b      <= '0;
            alu_cin    <= 1'b0;
            alu_mode   <= '0;
            op_load    <= 1'b0;
            acc        <= '0;
            res_valid  <= 1'b0;
            res_ovf    <= 1'b0;
            ovf_sticky <= 1'b0;
        end else begin
            res_valid <= res_valid_d;
            if (pop) begin
                alu_b    <= head.b;
                alu_cin  <= head.cin;
                alu_mode <= head.mode;
                op_load  <= head.load;
            end
            if (capture) begin
                if (op_load) begin
                    acc        <= alu_b;
                    res_ovf    <= 1'b0;
                    ovf_sticky <= 1'b0;
                end else begin
                    acc     <= alu_r;
                    res_ovf <= ovf_now;
                    if (ovf_now) begin
                        ovf_sticky <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
